// File: rtl/key_event_decoder.sv
// Key gesture decoder: classifies a debounced active-low key into short click,
// double click and long press events, with a running count of emitted events.
module key_event_decoder #(
  parameter logic [31:0] LONG_CYC = 32'd50000000,
  parameter logic [31:0] DBL_CYC  = 32'd15000000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       key_n,
  output logic       short_p,
  output logic       double_p,
  output logic       long_p,
  output logic       hold_o,
  output logic       busy_o,
  output logic [7:0] evt_cnt
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_P1,
    S_GAP,
    S_P2,
    S_LONG
  } state_t;

  state_t      state_q, state_d;
  logic        key_d_q;
  logic [31:0] cnt_q, cnt_d;
  logic        short_q, short_d;
  logic        double_q, double_d;
  logic        long_q, long_d;
  logic        hold_q, hold_d;
  logic        busy_q, busy_d;
  logic [7:0]  evt_cnt_q, evt_cnt_d;
  logic        press_edge;
  logic        release_lvl;

  always_comb begin
    state_d     = state_q;
    short_d     = 1'b0;
    double_d    = 1'b0;
    long_d      = 1'b0;
    press_edge  = key_d_q & ~key_n;
    release_lvl = key_n;

    // Release in P1 and press in GAP take priority over their timeouts.
    unique case (state_q)
      S_IDLE: if (press_edge) state_d = S_P1;
      S_P1: begin
        if (release_lvl) begin
          state_d = S_GAP;
        end else if (cnt_q == LONG_CYC - 32'd1) begin
          state_d = S_LONG;
          long_d  = 1'b1;
        end
      end
      S_GAP: begin
        if (!key_n) begin
          state_d = S_P2;
        end else if (cnt_q == DBL_CYC - 32'd1) begin
          state_d = S_IDLE;
          short_d = 1'b1;
        end
      end
      S_P2: begin
        if (release_lvl) begin
          state_d  = S_IDLE;
          double_d = 1'b1;
        end
      end
      S_LONG: if (release_lvl) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == S_P1 || state_q == S_GAP) begin
      cnt_d = cnt_q + 32'd1;
    end else begin
      cnt_d = cnt_q;
    end

    evt_cnt_d = evt_cnt_q;
    if (short_d || double_d || long_d) evt_cnt_d = evt_cnt_q + 8'd1;

    hold_d = (state_d == S_LONG);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      key_d_q   <= 1'b1;
      cnt_q     <= '0;
      short_q   <= 1'b0;
      double_q  <= 1'b0;
      long_q    <= 1'b0;
      hold_q    <= 1'b0;
      busy_q    <= 1'b0;
      evt_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      key_d_q   <= key_n;
      cnt_q     <= cnt_d;
      short_q   <= short_d;
      double_q  <= double_d;
      long_q    <= long_d;
      hold_q    <= hold_d;
      busy_q    <= busy_d;
      evt_cnt_q <= evt_cnt_d;
    end
  end

  assign short_p  = short_q;
  assign double_p = double_q;
  assign long_p   = long_q;
  assign hold_o   = hold_q;
  assign busy_o   = busy_q;
  assign evt_cnt  = evt_cnt_q;

endmodule

// File: tb/tb_key_event_decoder.sv
// Bench for key_event_decoder: timestamp-based gesture model checked every cycle,
// plus directed scenarios with hand-computed edge offsets and counts.
module tb_key_event_decoder;

  localparam int LC = 20;
  localparam int DC = 10;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       key_n = 1'b1;
  logic       short_p, double_p, long_p, hold_o, busy_o;
  logic [7:0] evt_cnt;

  key_event_decoder #(.LONG_CYC(32'd20), .DBL_CYC(32'd10)) dut (
    .clk(clk), .rstn(rstn), .key_n(key_n),
    .short_p(short_p), .double_p(double_p), .long_p(long_p),
    .hold_o(hold_o), .busy_o(busy_o), .evt_cnt(evt_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Gesture model: tracks where the key is within a click sequence and the edge
  // number at which the current press/gap began; timeouts are edge differences.
  bit       m_in_seq = 0, m_second = 0, m_down = 0, m_long = 0, m_prev = 1;
  int       m_n = 0, m_t0 = 0;
  bit       e_s = 0, e_d = 0, e_l = 0;
  bit [7:0] e_evt = '0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_in_seq = 0; m_second = 0; m_down = 0; m_long = 0; m_prev = 1;
      e_s = 0; e_d = 0; e_l = 0; e_evt = '0;
    end else begin
      m_n++;
      e_s = 0; e_d = 0; e_l = 0;
      if (!m_in_seq) begin
        if (m_prev && !key_n) begin
          m_in_seq = 1; m_down = 1; m_second = 0; m_t0 = m_n;
        end
      end else if (m_long) begin
        if (key_n) begin m_in_seq = 0; m_long = 0; end
      end else if (m_down && !m_second) begin
        if (key_n) begin
          m_down = 0; m_t0 = m_n;
        end else if (m_n - m_t0 == LC) begin
          m_long = 1; e_l = 1;
        end
      end else if (!m_down) begin
        if (!key_n) begin
          m_down = 1; m_second = 1;
        end else if (m_n - m_t0 == DC) begin
          m_in_seq = 0; e_s = 1;
        end
      end else if (key_n) begin
        m_in_seq = 0; e_d = 1;
      end
      if (e_s || e_d || e_l) e_evt = e_evt + 8'd1;
      m_prev = key_n;
    end
  end

  int n_short = 0, n_double = 0, n_long = 0, n_hold = 0;
  int t_short = -1, t_double = -1, t_long = -1;

  always @(negedge clk) begin
    checks++;
    if ({short_p, double_p, long_p, hold_o, busy_o, evt_cnt} ===
        {e_s, e_d, e_l, m_long, m_in_seq, e_evt}) begin
      passes++;
    end else begin
      $display("FAIL model_cmp cyc=%0d got s%b d%b l%b h%b b%b evt=%0d expected s%b d%b l%b h%b b%b evt=%0d",
               cyc, short_p, double_p, long_p, hold_o, busy_o, evt_cnt,
               e_s, e_d, e_l, m_long, m_in_seq, e_evt);
    end
    if (short_p === 1'b1)  begin n_short++;  t_short = cyc;  end
    if (double_p === 1'b1) begin n_double++; t_double = cyc; end
    if (long_p === 1'b1)   begin n_long++;   t_long = cyc;   end
    if (hold_o === 1'b1)   n_hold++;
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  // Holds key_n at v for n sampling edges; returns 2 time units after the last one.
  task automatic drive(input bit v, input int n);
    key_n = v;
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic do_reset(input bit kv, input int n);
    rstn = 1'b0;
    key_n = kv;
    repeat (n) @(posedge clk);
    #2 rstn = 1'b1;
  endtask

  int p_edge, r_edge, s0, d0, l0, h0;

  initial begin
    @(posedge clk); #2;
    do_reset(1'b1, 2);
    check("reset_evt", int'(evt_cnt), 0);
    check("reset_busy", int'(busy_o), 0);

    // Short click: pulse on 10th edge after the release is sampled.
    drive(1, 3); s0 = n_short; d0 = n_double; l0 = n_long;
    drive(0, 5); drive(1, 1); r_edge = cyc; drive(1, 14);
    check("short_offset", t_short - r_edge, 10);
    check("short_count", n_short - s0, 1);
    check("short_others", (n_double - d0) + (n_long - l0), 0);
    check("short_evt", int'(evt_cnt), 1);

    // Double click: pulse on the edge that samples the second release.
    do_reset(1'b1, 2); drive(1, 3); s0 = n_short; d0 = n_double;
    drive(0, 5); drive(1, 4); drive(0, 3); drive(1, 1); r_edge = cyc; drive(1, 14);
    check("double_offset", t_double - r_edge, 0);
    check("double_count", n_double - d0, 1);
    check("double_no_short", n_short - s0, 0);
    check("double_evt", int'(evt_cnt), 1);

    // Long press of 30 cycles: long_p 20 edges after the press edge, hold for 10 cycles.
    do_reset(1'b1, 2); drive(1, 3); l0 = n_long; h0 = n_hold; s0 = n_short;
    drive(0, 1); p_edge = cyc; drive(0, 29); drive(1, 1);
    check("busy_after_long", int'(busy_o), 0);
    drive(1, 14);
    check("long_offset", t_long - p_edge, 20);
    check("long_count", n_long - l0, 1);
    check("hold_cycles", n_hold - h0, 10);
    check("long_no_short", n_short - s0, 0);
    check("long_evt", int'(evt_cnt), 1);

    // Release at P1 cnt==19 stays short; second press at GAP cnt==9 becomes a double.
    do_reset(1'b1, 2); drive(1, 3); s0 = n_short; d0 = n_double; l0 = n_long;
    drive(0, 20); drive(1, 10); drive(0, 4); drive(1, 14);
    check("bnd_no_long", n_long - l0, 0);
    check("bnd_no_short", n_short - s0, 0);
    check("bnd_double", n_double - d0, 1);

    // Reset in GAP at cnt==4 aborts the click.
    do_reset(1'b1, 2); drive(1, 2); s0 = n_short;
    drive(0, 5); drive(1, 1); drive(1, 4);
    check("gap_busy_before_rst", int'(busy_o), 1);
    rstn = 1'b0; #1;
    check("gap_rst_outputs", int'({short_p, double_p, long_p, hold_o, busy_o, evt_cnt}), 0);
    repeat (3) @(posedge clk); #2 rstn = 1'b1;
    drive(1, 15);
    check("gap_rst_no_short", n_short - s0, 0);
    check("gap_rst_evt", int'(evt_cnt), 0);

    // Key held low through reset is a press edge on the first edge afterwards.
    do_reset(1'b0, 2); drive(0, 1);
    check("held_press_busy", int'(busy_o), 1);
    drive(0, 2); drive(1, 14);

    // 256 short clicks wrap evt_cnt back to zero.
    do_reset(1'b1, 2); drive(1, 2); s0 = n_short;
    for (int i = 0; i < 256; i++) begin
      drive(0, 5); drive(1, 12);
    end
    check("wrap_shorts", n_short - s0, 256);
    check("wrap_evt", int'(evt_cnt), 0);

    // Random durations clustered around the timeout boundaries, with sporadic resets.
    do_reset(1'b1, 2);
    for (int seg = 0; seg < 600; seg++) begin
      if ($urandom_range(0, 39) == 0) begin
        do_reset(1'($urandom_range(0, 1)), int'($urandom_range(1, 3)));
      end else if (seg % 2 == 0) begin
        drive(0, int'($urandom_range(1, 25)));
      end else begin
        drive(1, int'($urandom_range(1, 14)));
      end
    end
    drive(1, 40);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/key_event_decoder.md
KEY_EVENT_DECODER -- requirements
Module: key_event_decoder

Interface
REQ-001 Parameter LONG_CYC, default 32'd50000000: press duration in clk cycles classified as a long press; SHALL be >= 2.
REQ-002 Parameter DBL_CYC, default 32'd15000000: maximum release-to-press gap in clk cycles for a double click; SHALL be >= 2.
REQ-003 Port clk, input, 1: system clock; all logic on rising edge.
REQ-004 Port rstn, input, 1: reset, asynchronous, active-low.
REQ-005 Port key_n, input, 1: debounced key level, active-low (0 = pressed, 1 = idle), synchronous to clk.
REQ-006 Port short_p, output, 1: one-cycle pulse, single short click.
REQ-007 Port double_p, output, 1: one-cycle pulse, double click.
REQ-008 Port long_p, output, 1: one-cycle pulse, long press reached.
REQ-009 Port hold_o, output, 1: level, high while a long press is held.
REQ-010 Port busy_o, output, 1: level, high whenever FSM is not IDLE.
REQ-011 Port evt_cnt, output, 8: running count of emitted event pulses.

Function
REQ-012 Registered copy key_d <= key_n every cycle; press edge = key_d==1 && key_n==0; release = key_n==1.
REQ-013 A single 32-bit counter cnt SHALL be cleared to 0 on every state transition and otherwise SHALL increment by 1 each cycle in P1 and GAP; it holds in other states.
REQ-014 FSM states: IDLE, P1 (first press), GAP (released, waiting), P2 (second press), LONG.
REQ-015 IDLE: press edge -> P1; otherwise stay.
REQ-016 P1: release -> GAP; else cnt==LONG_CYC-1 -> LONG; else stay.
REQ-017 P1 boundary: release and cnt==LONG_CYC-1 in the same cycle -> GAP (release wins).
REQ-018 GAP: key_n==0 -> P2; else cnt==DBL_CYC-1 -> IDLE with short_p; else stay.
REQ-019 GAP boundary: key_n==0 and cnt==DBL_CYC-1 in the same cycle -> P2 (press wins); no short_p.
REQ-020 P2: release -> IDLE with double_p; P2 has no duration limit and no long detection.
REQ-021 LONG: release -> IDLE with no pulse; long_p is issued only on entry P1->LONG.
REQ-022 Pulses are registered: high for exactly the one cycle following the clock edge that performs the transition; at most one pulse is high in any cycle.
REQ-023 hold_o SHALL be registered, high exactly while state==LONG; busy_o SHALL be high exactly while state!=IDLE.
REQ-024 evt_cnt SHALL increment by 1 in the same edge that asserts any pulse; it wraps 8'hFF -> 8'h00.
REQ-025 A press edge in LONG, P2 or P1 has no effect beyond the transitions listed above.

Reset
REQ-026 rstn low SHALL immediately force: state IDLE, cnt 0, key_d 1, short_p/double_p/long_p 0, hold_o 0, busy_o 0, evt_cnt 0.
REQ-027 Reset asserted mid-sequence (any state) SHALL abort it with no pulse emitted; after release, a key held low is seen as a press edge on the first clk edge (key_d resets to 1).

Verification (LONG_CYC=20, DBL_CYC=10)
REQ-028 Short click: key_n low 5 cycles, then high -> short_p high one cycle, rising on the 10th edge after release sampled; evt_cnt 0->1; no other pulse.
REQ-029 Double click: low 5, high 4, low 3, high -> double_p one cycle on the edge after the second release; short_p never asserts; evt_cnt=1.
REQ-030 Long press: low 30 cycles -> long_p rises on the 20th edge after press sampled; hold_o high from that edge until the edge after release; busy_o low afterwards; evt_cnt=1.
REQ-031 Boundaries: release exactly at P1 cnt==19 -> GAP, no long_p; second press exactly at GAP cnt==9 -> P2, later double_p, no short_p.
REQ-032 Reset mid-GAP: press 5, release, rstn low 3 cycles at GAP cnt==4 -> all outputs 0, no short_p ever; 256 short clicks -> evt_cnt returns to 0.
